// File: rtl/split_buffered.sv
// One-to-two stream splitter: each token is steered by its select bit into the
// A or B output FIFO, so a stalled consumer only blocks traffic headed its way.
module split_buffered_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head;
    logic             pop;

    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign valid    = (wr_ptr != rd_ptr);
    assign pop      = valid && ready;
    assign wr_next  = wr_ptr + {{AW{1'b0}}, push};
    assign rd_next  = rd_ptr + {{AW{1'b0}}, pop};
    assign data_out = head;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    // The head is registered so the output holds its last token once the FIFO
    // drains; a token written into the slot becoming head is forwarded directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (wr_next != rd_next) begin
                if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
                    head <= data_in;
                end else begin
                    head <= mem[rd_next[AW-1:0]];
                end
            end
        end
    end
endmodule

module split_buffered #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    logic a_full, b_full;
    logic push_a, push_b;

    // in_valid gates only the pushes, never in_ready.
    assign in_ready = in_sel ? !b_full : !a_full;
    assign push_a   = in_valid && !in_sel && !a_full;
    assign push_b   = in_valid &&  in_sel && !b_full;

    split_buffered_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk      (clk),
        .rst      (rst),
        .push     (push_a),
        .data_in  (in_data),
        .full     (a_full),
        .valid    (a_valid),
        .ready    (a_ready),
        .data_out (a_data)
    );

    split_buffered_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk      (clk),
        .rst      (rst),
        .push     (push_b),
        .data_in  (in_data),
        .full     (b_full),
        .valid    (b_valid),
        .ready    (b_ready),
        .data_out (b_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (push_a) a_count <= a_count + 1'b1;
            if (push_b) b_count <= b_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_split_buffered.sv
// Bench for split_buffered: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_split_buffered;
    localparam int WIDTH = 33;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 0;
    logic             rst;
    logic             in_valid, in_sel, in_ready;
    logic [WIDTH-1:0] in_data;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic [CNT_W-1:0] a_count, b_count;

    split_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two queues and two counters driven by the handshake rules.
    logic [WIDTH-1:0] qa[$], qb[$];
    logic [WIDTH-1:0] last_a, last_b;
    logic [CNT_W-1:0] m_cnt_a, m_cnt_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete(); qb.delete();
            m_cnt_a = '0; m_cnt_b = '0;
            last_a = '0; last_b = '0;
        end else begin
            logic acc;
            acc = in_valid && (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
            if (qa.size() > 0 && a_ready) void'(qa.pop_front());
            if (qb.size() > 0 && b_ready) void'(qb.pop_front());
            if (acc) begin
                if (in_sel) begin qb.push_back(in_data); m_cnt_b = m_cnt_b + 1'b1; end
                else        begin qa.push_back(in_data); m_cnt_a = m_cnt_a + 1'b1; end
            end
        end
    end

    always @(negedge clk) begin
        chk("a_valid", a_valid, qa.size() != 0);
        chk("b_valid", b_valid, qb.size() != 0);
        if (qa.size() != 0) last_a = qa[0];
        if (qb.size() != 0) last_b = qb[0];
        chk("a_data", a_data, last_a);
        chk("b_data", b_data, last_b);
        chk("a_count", a_count, m_cnt_a);
        chk("b_count", b_count, m_cnt_b);
        if (!$isunknown(in_sel))
            chk("in_ready", in_ready, in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Offer one token; returns the number of cycles it was presented.
    task automatic send(input logic sel, input logic [WIDTH-1:0] d, input bit rand_a,
                        output int used);
        logic acc;
        used = 0;
        in_valid = 1; in_sel = sel; in_data = d;
        for (int k = 0; k < 20; k++) begin
            if (rand_a) a_ready = (k >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            @(negedge clk); #1;
            used = k + 1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    int u;

    initial begin
        rst = 1; in_valid = 0; in_sel = 0; in_data = '0; a_ready = 1; b_ready = 1;
        #12 rst = 0;
        cycles(1);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_counts", {a_count, b_count}, 0);
        chk("rst_in_ready_a", in_ready, 1);
        in_sel = 1; #1;
        chk("rst_in_ready_b", in_ready, 1);

        // Alternating routing
        send(0, 33'h0_0000_0011, 0, u);
        chk("alt_a_data", a_data, 33'h0_0000_0011);
        chk("alt_a_valid", a_valid, 1);
        send(1, 33'h1_0000_0022, 0, u);
        chk("alt_b_data", b_data, 33'h1_0000_0022);
        chk("alt_counts", {a_count, b_count}, {4'd1, 4'd1});
        cycles(2);

        // Independent stall on B
        b_ready = 0;
        send(1, 33'h1_0000_00B1, 0, u);
        send(1, 33'h1_0000_00B2, 0, u);
        in_valid = 1; in_sel = 1; in_data = 33'h1_0000_00B3; #1;
        chk("stall_in_ready", in_ready, 0);
        cycles(1);
        send(0, 33'h0_0000_00A1, 0, u);
        chk("stall_a_data", a_data, 33'h0_0000_00A1);
        chk("stall_b_head", b_data, 33'h1_0000_00B1);
        chk("stall_b_count", b_count, 4'd3);
        b_ready = 1;
        cycles(3);
        chk("stall_b_drained", b_valid, 0);
        chk("stall_b_last", b_data, 33'h1_0000_00B2);

        // Full FIFO with simultaneous pop
        a_ready = 0;
        send(0, 33'h0_0000_00C1, 0, u);
        send(0, 33'h0_0000_00C2, 0, u);
        a_ready = 1; in_valid = 1; in_sel = 0; in_data = 33'h0_0000_00C3; #1;
        chk("fullpop_in_ready", in_ready, 0);
        send(0, 33'h0_0000_00C3, 0, u);
        chk("fullpop_wait", u, 2);
        cycles(3);
        chk("fullpop_last", a_data, 33'h0_0000_00C3);

        // Unknown select with no valid must not disturb anything
        in_valid = 0; in_sel = 1'bx;
        cycles(3);
        in_sel = 0;
        chk("xsel_a_count", a_count, 4'd5);

        // Reset mid-operation
        a_ready = 0; b_ready = 0;
        send(0, 33'h0_0000_00D1, 0, u);
        send(0, 33'h0_0000_00D2, 0, u);
        send(1, 33'h1_0000_00D3, 0, u);
        #3 rst = 1;
        #1;
        chk("mid_rst_a_valid", a_valid, 0);
        chk("mid_rst_b_valid", b_valid, 0);
        chk("mid_rst_a_data", a_data, 0);
        @(negedge clk); #2 rst = 0;
        a_ready = 1; b_ready = 1;
        cycles(4);
        chk("mid_rst_counts", {a_count, b_count}, 0);

        // Pointer wrap and counter rollover
        for (int i = 0; i < 20; i++) send(0, WIDTH'(i), 1, u);
        a_ready = 1;
        cycles(4);
        chk("roll_a_count", a_count, 4'd4);
        chk("roll_a_valid", a_valid, 0);
        chk("roll_a_last", a_data, 33'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
